// File: rtl/mux8to1_rr.sv
// -----------------------------------------------------------------------------
// mux8to1_rr
//
// Merges eight valid/ready producer lanes onto one registered valid/ready
// output stream. Lanes are chosen round-robin, and every output beat carries
// the index of the lane it came from, so a 1-to-8 demux further down can route
// it back out. The output stage is a one-entry register that is reloaded in the
// same cycle it is consumed, which gives one beat per cycle under a steady
// out_ready.
//
// Parameters:
//   DATA_W     width of each lane's data word
//   MAX_BURST  longest run of consecutive grants to one lane (1..15); only
//              meaningful when MUX_STICKY_GRANT_EN is defined
//
// Optional feature (compile-time macro MUX_STICKY_GRANT_EN):
//   When defined, the most recently granted lane is granted again ahead of
//   round-robin order while it stays valid and its burst count is below
//   MAX_BURST. When undefined, arbitration is pure round-robin and no burst
//   counter exists.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   [7:0]         per-lane valid, bit i is lane i
//   in_data    in   [8*DATA_W-1:0] lane i data at [i*DATA_W +: DATA_W]
//   in_ready   out  [7:0]         per-lane ready, at most one bit set
//   out_valid  out  registered output beat valid
//   out_data   out  [DATA_W-1:0]  registered output data
//   out_sel    out  [2:0]         registered source lane of out_data
//   out_ready  in   downstream accept
// -----------------------------------------------------------------------------
module mux8to1_rr #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            in_valid,
  input  logic [8*DATA_W-1:0]   in_data,
  output logic [7:0]            in_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic [2:0]            out_sel,
  input  logic                  out_ready
);

  // Output register occupancy.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e              state_q;
  logic [DATA_W-1:0]   data_q;
  logic [2:0]          sel_q;
  logic [2:0]          last_grant_q;

  logic                load_en_s;
  logic                rr_found_s;
  logic [2:0]          rr_idx_s;
  logic                grant_found_s;
  logic [2:0]          grant_idx_s;
  logic                xfer_s;
  logic [DATA_W-1:0]   grant_data_s;

  // Decode a lane index into its one-hot ready pattern.
  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    logic [7:0] oh;
    oh = 8'h00;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  // Extract one lane's word from the packed lane bus.
  function automatic logic [DATA_W-1:0] lane_word(input logic [8*DATA_W-1:0] bus,
                                                  input logic [2:0]          idx);
    return bus[int'(idx)*DATA_W +: DATA_W];
  endfunction

  // A new beat may enter when the output register is empty or is being drained.
  assign load_en_s = (state_q == ST_EMPTY) || out_ready;

  // Round-robin search: first valid lane after last_grant, wrapping 7 -> 0.
  // The final step (k = 8) lands back on last_grant itself, so a lone lane
  // still wins.
  always_comb begin
    logic [2:0] cand;
    rr_found_s = 1'b0;
    rr_idx_s   = 3'd0;
    cand       = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      cand = last_grant_q + 3'(k);
      if (!rr_found_s && in_valid[cand]) begin
        rr_found_s = 1'b1;
        rr_idx_s   = cand;
      end else begin
        rr_found_s = rr_found_s;
      end
    end
  end

`ifdef MUX_STICKY_GRANT_EN
  localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

  logic [3:0] burst_cnt_q;
  logic [3:0] burst_cnt_d;
  logic       sticky_s;

  // A zero count means nothing has been granted since reset, so the reset
  // value of last_grant (7) must not be treated as a live burst.
  assign sticky_s = (burst_cnt_q != 4'd0) && (burst_cnt_q < MAX_BURST_C)
                    && in_valid[last_grant_q];

  // Sticky re-grant takes precedence over round-robin order.
  always_comb begin
    if (sticky_s) begin
      grant_found_s = 1'b1;
      grant_idx_s   = last_grant_q;
    end else begin
      grant_found_s = rr_found_s;
      grant_idx_s   = rr_idx_s;
    end
  end

  // Extend the burst only while it is still below the limit; a lane that
  // wins again through round-robin after yielding starts a fresh burst.
  always_comb begin
    if ((grant_idx_s == last_grant_q) && (burst_cnt_q != 4'd0)
        && (burst_cnt_q < MAX_BURST_C)) begin
      burst_cnt_d = burst_cnt_q + 4'd1;
    end else begin
      burst_cnt_d = 4'd1;
    end
  end

  // Burst counter, advanced on every accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt_q <= 4'd0;
    end else if (xfer_s) begin
      burst_cnt_q <= burst_cnt_d;
    end else begin
      burst_cnt_q <= burst_cnt_q;
    end
  end
`else
  // Pure round-robin grant.
  always_comb begin
    grant_found_s = rr_found_s;
    grant_idx_s   = rr_idx_s;
  end
`endif

  // rst_n gates the handshake so no producer sees ready while in reset.
  assign xfer_s       = rst_n && load_en_s && grant_found_s;
  assign grant_data_s = lane_word(in_data, grant_idx_s);

  // Ready is raised only toward the granted lane.
  always_comb begin
    if (xfer_s) begin
      in_ready = onehot8(grant_idx_s);
    end else begin
      in_ready = 8'h00;
    end
  end

  // Output stage FSM together with its data, source-lane and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      data_q       <= '0;
      sel_q        <= 3'd0;
      last_grant_q <= 3'd7;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (xfer_s) begin
            state_q      <= ST_FULL;
            data_q       <= grant_data_s;
            sel_q        <= grant_idx_s;
            last_grant_q <= grant_idx_s;
          end else begin
            state_q <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (xfer_s) begin
            // Consumed and refilled in the same cycle.
            state_q      <= ST_FULL;
            data_q       <= grant_data_s;
            sel_q        <= grant_idx_s;
            last_grant_q <= grant_idx_s;
          end else if (out_ready) begin
            // Consumed with nothing behind it; data/sel keep stale values.
            state_q <= ST_EMPTY;
          end else begin
            // Back-pressured: hold everything.
            state_q <= ST_FULL;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
        end
      endcase
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_sel   = sel_q;

endmodule

// File: tb/tb_mux8to1_rr.sv
// -----------------------------------------------------------------------------
// tb_mux8to1_rr
//
// Bench for mux8to1_rr (default build: pure round-robin). Inputs are driven
// on the falling edge, in_ready is sampled 1 ns later, registered outputs are
// sampled on the following falling edge.
// -----------------------------------------------------------------------------
module tb_mux8to1_rr;

  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;

  logic              clk;
  logic              rst_n;
  logic [7:0]        in_valid;
  logic [8*DATA_W-1:0] in_data;
  logic [7:0]        in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        out_sel;
  logic              out_ready;

  int tests_run;
  int tests_failed;

  mux8to1_rr #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          m_last;
  bit          m_valid;
  logic [7:0]  m_data;
  int          m_sel;
  int          m_burst;

  task automatic model_reset();
    m_last  = 7;
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_sel   = 0;
    m_burst = 0;
  endtask

  // Lane that wins this cycle, or -1 when no lane is valid.
  function automatic int model_grant(logic [7:0] v);
`ifdef MUX_STICKY_GRANT_EN
    if (m_burst != 0 && m_burst < MAX_BURST && v[m_last]) return m_last;
`endif
    for (int k = 1; k <= 8; k++) begin
      int lane;
      lane = (m_last + k) % 8;
      if (v[lane]) return lane;
    end
    return -1;
  endfunction

  function automatic logic [7:0] model_ready(logic [7:0] v, logic rdy);
    int g;
    g = model_grant(v);
    if (g >= 0 && (!m_valid || rdy)) return 8'(1 << g);
    return 8'h00;
  endfunction

  task automatic model_advance(input logic [7:0] v, input logic rdy,
                               input logic [63:0] d);
    int g;
    g = model_grant(v);
    if (!m_valid || rdy) begin
      if (g >= 0) begin
        m_burst = (g == m_last && m_burst != 0 && m_burst < MAX_BURST) ? m_burst + 1 : 1;
        m_valid = 1'b1;
        m_data  = d[g*8 +: 8];
        m_sel   = g;
        m_last  = g;
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle and check in_ready, then the registered outputs.
  task automatic drive_check(input string name, input logic [7:0] v, input logic rdy,
                             input logic [63:0] d, input logic [7:0] er,
                             input logic ev, input logic [2:0] es, input logic [7:0] ed);
    in_valid  = v;
    out_ready = rdy;
    in_data   = d;
    #1;
    check({name, ".in_ready"}, in_ready, er);
    @(posedge clk);
    @(negedge clk);
    check({name, ".out_valid"}, out_valid, ev);
    if (ev) begin
      check({name, ".out_sel"}, out_sel, es);
      check({name, ".out_data"}, out_data, ed);
    end
  endtask

  task automatic step_directed(input string name, input logic [7:0] v, input logic rdy,
                               input logic [63:0] d, input logic [7:0] er,
                               input logic ev, input logic [2:0] es, input logic [7:0] ed);
    model_advance(v, rdy, d);
    drive_check(name, v, rdy, d, er, ev, es, ed);
  endtask

  typedef struct {
    logic [7:0] v;
    logic       rdy;
    logic [7:0] er;
    logic       ev;
    logic [2:0] es;
    logic [7:0] ed;
  } vec_t;

  vec_t tbl [15];
  logic [63:0] lane_pat;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    for (int i = 0; i < 8; i++) lane_pat[i*8 +: 8] = 8'(8'h10 + i);

    // Backpressure, wrap-around and idle corners, starting from last_grant=7.
    tbl[0]  = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 8'h00};
    tbl[1]  = '{8'h44, 1'b0, 8'h04, 1'b1, 3'd2, 8'h12};
    tbl[2]  = '{8'h44, 1'b0, 8'h00, 1'b1, 3'd2, 8'h12};
    tbl[3]  = '{8'h44, 1'b0, 8'h00, 1'b1, 3'd2, 8'h12};
    tbl[4]  = '{8'h44, 1'b0, 8'h00, 1'b1, 3'd2, 8'h12};
    tbl[5]  = '{8'h44, 1'b0, 8'h00, 1'b1, 3'd2, 8'h12};
    tbl[6]  = '{8'h44, 1'b0, 8'h00, 1'b1, 3'd2, 8'h12};
    tbl[7]  = '{8'h44, 1'b1, 8'h40, 1'b1, 3'd6, 8'h16};
    tbl[8]  = '{8'h80, 1'b1, 8'h80, 1'b1, 3'd7, 8'h17};
    tbl[9]  = '{8'h81, 1'b1, 8'h01, 1'b1, 3'd0, 8'h10};
    tbl[10] = '{8'h81, 1'b1, 8'h80, 1'b1, 3'd7, 8'h17};
    tbl[11] = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 8'h00};
    tbl[12] = '{8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00};
    tbl[13] = '{8'h01, 1'b0, 8'h01, 1'b1, 3'd0, 8'h10};
    tbl[14] = '{8'h02, 1'b0, 8'h00, 1'b1, 3'd0, 8'h10};

    // Reset held for 3 cycles with every lane requesting.
    rst_n     = 1'b0;
    in_valid  = 8'hFF;
    in_data   = lane_pat;
    out_ready = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset.out_valid", out_valid, 1'b0);
      check("reset.in_ready", in_ready, 8'h00);
    end

    // Release and idle.
    in_valid = 8'h00;
    rst_n    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle.out_valid", out_valid, 1'b0);
      check("idle.out_data", out_data, 8'h00);
      check("idle.out_sel", out_sel, 3'd0);
      check("idle.in_ready", in_ready, 8'h00);
    end

    for (int i = 0; i < 15; i++) begin
      step_directed($sformatf("tbl%0d", i), tbl[i].v, tbl[i].rdy, lane_pat,
                    tbl[i].er, tbl[i].ev, tbl[i].es, tbl[i].ed);
    end

    // Single lane 5 carrying 0xA5 while the register drains.
    begin
      logic [63:0] d;
      d = 64'h0;
      d[5*8 +: 8] = 8'hA5;
      step_directed("single", 8'h20, 1'b1, d, 8'h20, 1'b1, 3'd5, 8'hA5);
    end

    // Asynchronous reset between edges while a beat is held.
    in_valid  = 8'h00;
    out_ready = 1'b0;
    #2;
    check("midrst.pre_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst.out_valid", out_valid, 1'b0);
    check("midrst.in_ready", in_ready, 8'h00);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Full contention: 0..7 twice.
    for (int k = 0; k < 16; k++) begin
      step_directed($sformatf("full%0d", k), 8'hFF, 1'b1, lane_pat,
                    8'(1 << (k % 8)), 1'b1, 3'(k % 8), 8'(8'h10 + (k % 8)));
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [7:0]  v;
      logic        rdy;
      logic [63:0] d;
      logic [7:0]  er;
      v   = 8'($urandom);
      if (i % 3 == 0) v = v & 8'($urandom);
      if (i % 7 == 0) v = 8'h00;
      rdy = ($urandom_range(0, 3) != 0);
      d   = {$urandom, $urandom};
      er  = model_ready(v, rdy);
      model_advance(v, rdy, d);
      drive_check($sformatf("rand%0d", i), v, rdy, d, er, m_valid, 3'(m_sel), m_data);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
